// File: rtl/bus_ram.sv
// bus_ram: byte-addressed little-endian RAM on a valid/ready request/response bus,
// with programmable wait states and misaligned accesses split across two word cycles.
module bus_ram #(
  parameter logic [31:0] RAM_START   = 32'h0000_0000,
  parameter int          RAM_SIZE    = 256,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(RAM_SIZE);
  typedef enum logic [2:0] {IDLE, WAIT, ACC0, ACC1, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0] r_wcnt;
  logic [AW-1:0] r_off;
  logic [1:0] r_lo;
  logic [2:0] r_nb;
  logic [31:0] r_wdata, r_raw, r_rdata;
  logic r_we, r_signed, r_skip, r_fault, r_cross, r_err;
  logic [2:0] w_nb;
  logic [32:0] w_rel, w_rel_last;
  logic w_fault, w_skip, w_cross;
  logic [31:0] w_raw_next, w_ext;
  logic [3:0] w_sel;
  logic [AW-1:0] w_idx [4];
  logic [7:0] r_mem [RAM_SIZE];
  assign w_nb = req_size == 2'b11 ? 3'd4 : req_size == 2'b10 ? 3'd2 : {2'b00, req_size[0]};
  // offset below the base shows up as bit 32 set; the last byte is checked without 32-bit wrap
  assign w_rel = {1'b0, req_addr} - {1'b0, RAM_START};
  assign w_rel_last = w_rel + 33'(w_nb) - 33'd1;
  assign w_fault = req_size != 2'b00 && (w_rel[32] || w_rel_last >= 33'(RAM_SIZE));
  assign w_skip = req_size == 2'b00 || w_fault;
  assign w_cross = 4'(req_addr[1:0]) + 4'(w_nb) > 4'd4;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (req_valid) w_next = (WAIT_STATES > 0 && !w_skip) ? WAIT : ACC0;
      WAIT: if (r_wcnt == 4'd0) w_next = ACC0;
      ACC0: w_next = (!r_skip && r_cross) ? ACC1 : RESP;
      ACC1: w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    rsp_rdata = r_rdata;
    rsp_err = r_err;
  end
  // skipped requests (faults, size none) still pass through ACC0 as a dead cycle so every response lands one cycle after accept
  always_comb begin
    w_raw_next = r_raw;
    w_sel = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx[k] = r_off + AW'(k);
      w_sel[k] = !r_skip && 3'(k) < r_nb && (r_state == ACC0 || r_state == ACC1) &&
                 ((r_state == ACC0) == (3'(r_lo) + 3'(k) < 3'd4));
      if (w_sel[k]) w_raw_next[8*k +: 8] = r_mem[w_idx[k]];
    end
    w_ext = r_nb == 3'd1 ? {{24{r_signed & w_raw_next[7]}}, w_raw_next[7:0]} :
            r_nb == 3'd2 ? {{16{r_signed & w_raw_next[15]}}, w_raw_next[15:0]} : w_raw_next;
  end
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (w_sel[k] && r_we) r_mem[w_idx[k]] <= r_wdata[8*k +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wcnt <= '0;
      r_off <= '0;
      r_lo <= '0;
      r_nb <= '0;
      r_wdata <= '0;
      r_raw <= '0;
      r_rdata <= '0;
      r_we <= 1'b0;
      r_signed <= 1'b0;
      r_skip <= 1'b0;
      r_fault <= 1'b0;
      r_cross <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_wcnt <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
        r_off <= w_rel[AW-1:0];
        r_lo <= req_addr[1:0];
        r_nb <= w_nb;
        r_wdata <= req_wdata;
        r_raw <= '0;
        r_we <= req_we;
        r_signed <= req_signed;
        r_skip <= w_skip;
        r_fault <= w_fault;
        r_cross <= w_cross;
      end
      if (r_state == WAIT && r_wcnt != 4'd0) r_wcnt <= r_wcnt - 4'd1;
      if (r_state == ACC0 || r_state == ACC1) r_raw <= w_raw_next;
      if (w_next == RESP && r_state != RESP) begin
        r_rdata <= r_skip ? '0 : w_ext;
        r_err <= r_fault;
      end
    end
endmodule

// File: tb/tb_bus_ram.sv
// tb_bus_ram: directed vector table plus hand sequences for wait states, back-pressure and mid-access reset.
module tb_bus_ram;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req_valid = 0, req_ready, req_we = 0, req_signed = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic b_req_valid = 0, b_req_ready, b_req_we = 0, b_req_signed = 0, b_rsp_valid, b_rsp_ready = 0, b_rsp_err;
  logic [1:0] b_req_size = 0;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_rsp_rdata;
  int n_vec = 0, n_bad = 0;

  bus_ram dut0 (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));
  bus_ram #(.WAIT_STATES(3)) dut1 (.clk(clk), .rst_n(rst_n), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .req_addr(b_req_addr), .req_we(b_req_we), .req_size(b_req_size),
    .req_signed(b_req_signed), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err));

  typedef struct {
    logic we; logic [1:0] size; logic sgn; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic err; int lat; logic chk;
  } vec_t;
  vec_t v [25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 0;
    req_addr = $urandom; req_wdata = $urandom; req_we = ~we; req_size = ~size; req_signed = ~sgn;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, rd_h;
    logic er, er_h;
    int lat;
    v[0]  = '{1, 2'd3, 0, 32'h10, 32'h8899AABB, 32'h0, 0, 1, 0};
    v[1]  = '{0, 2'd1, 1, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 1, 1};
    v[2]  = '{0, 2'd1, 0, 32'h11, 32'h0, 32'h000000AA, 0, 1, 1};
    v[3]  = '{0, 2'd3, 1, 32'h10, 32'h0, 32'h8899AABB, 0, 1, 1};
    v[4]  = '{0, 2'd2, 1, 32'h12, 32'h0, 32'hFFFF8899, 0, 1, 1};
    v[5]  = '{0, 2'd2, 0, 32'h10, 32'h0, 32'h0000AABB, 0, 1, 1};
    v[6]  = '{1, 2'd1, 0, 32'h12, 32'hFFFFFF55, 32'h0, 0, 1, 0};
    v[7]  = '{0, 2'd3, 0, 32'h10, 32'h0, 32'h8855AABB, 0, 1, 1};
    v[8]  = '{1, 2'd3, 0, 32'h08, 32'h0, 32'h0, 0, 1, 0};
    v[9]  = '{1, 2'd3, 0, 32'h0C, 32'h0, 32'h0, 0, 1, 0};
    v[10] = '{1, 2'd2, 0, 32'h0B, 32'h1234, 32'h0, 0, 2, 0};
    v[11] = '{0, 2'd3, 0, 32'h08, 32'h0, 32'h34000000, 0, 1, 1};
    v[12] = '{0, 2'd3, 0, 32'h0C, 32'h0, 32'h00000012, 0, 1, 1};
    v[13] = '{0, 2'd2, 0, 32'h0A, 32'h0, 32'h00003400, 0, 1, 1};
    v[14] = '{0, 2'd2, 1, 32'h0B, 32'h0, 32'h00001234, 0, 2, 1};
    v[15] = '{0, 2'd3, 0, 32'h0A, 32'h0, 32'h00123400, 0, 2, 1};
    v[16] = '{1, 2'd3, 0, 32'hFC, 32'h11223344, 32'h0, 0, 1, 0};
    v[17] = '{0, 2'd3, 0, 32'hFE, 32'h0, 32'h0, 1, 1, 1};
    v[18] = '{1, 2'd3, 0, 32'hFE, 32'hDEADBEEF, 32'h0, 1, 1, 1};
    v[19] = '{0, 2'd2, 0, 32'hFE, 32'h0, 32'h00001122, 0, 1, 1};
    v[20] = '{0, 2'd1, 1, 32'h100, 32'h0, 32'h0, 1, 1, 1};
    v[21] = '{0, 2'd3, 0, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 1, 1};
    v[22] = '{1, 2'd0, 0, 32'h500, 32'hFFFFFFFF, 32'h0, 0, 1, 1};
    v[23] = '{0, 2'd3, 0, 32'hFC, 32'h0, 32'h11223344, 0, 1, 1};
    v[24] = '{0, 2'd1, 1, 32'hFF, 32'h0, 32'h00000011, 0, 1, 1};
    #12;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 check("rel_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 25; i++) begin
      xfer(v[i].we, v[i].size, v[i].sgn, v[i].addr, v[i].wdata, rd, er, lat);
      check($sformatf("v%0d_err", i), 32'(er), 32'(v[i].err));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].lat));
      if (v[i].chk) check($sformatf("v%0d_rdata", i), rd, v[i].rdata);
    end
    // three wait states with back-pressure; a new request is queued while the response is held
    @(negedge clk);
    b_req_valid = 1; b_req_we = 1; b_req_size = 2'd3; b_req_addr = 32'h20; b_req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 b_req_valid = 0;
    lat = 0;
    while (!b_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("ws3_wr_lat", 32'(lat), 32'd4);
    check("ws3_wr_err", 32'(b_rsp_err), 32'd0);
    rd_h = b_rsp_rdata; er_h = b_rsp_err;
    b_req_valid = 1; b_req_we = 0; b_req_size = 2'd3; b_req_addr = 32'h20;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 check("ws3_hold_valid", 32'(b_rsp_valid), 32'd1);
      check("ws3_hold_rdata", b_rsp_rdata, rd_h);
      check("ws3_hold_err", 32'(b_rsp_err), 32'(er_h));
      check("ws3_hold_ready", 32'(b_req_ready), 32'd0);
    end
    @(negedge clk) b_rsp_ready = 1;
    @(posedge clk);
    #1 b_rsp_ready = 0;
    check("ws3_after_valid", 32'(b_rsp_valid), 32'd0);
    check("ws3_after_ready", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    #1 b_req_valid = 0;
    lat = 0;
    while (!b_rsp_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    check("ws3_rd_lat", 32'(lat), 32'd4);
    check("ws3_rd_rdata", b_rsp_rdata, 32'hCAFEF00D);
    @(negedge clk) b_rsp_ready = 1;
    @(posedge clk);
    #1 b_rsp_ready = 0;
    // reset between ACC0 and ACC1 of a crossing word write
    xfer(1, 2'd3, 0, 32'h40, 32'h0, rd, er, lat);
    xfer(1, 2'd3, 0, 32'h44, 32'h0, rd, er, lat);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'd3; req_addr = 32'h42; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1 check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rdata", rsp_rdata, 32'd0);
    check("mid_rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 check("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
    xfer(0, 2'd3, 0, 32'h40, 32'h0, rd, er, lat);
    check("mid_rst_w0", rd, 32'hC3D40000);
    check("mid_rst_lat", 32'(lat), 32'd1);
    xfer(0, 2'd3, 0, 32'h44, 32'h0, rd, er, lat);
    check("mid_rst_w1", rd, 32'h00000000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
